// File: rtl/calc_resp_if.sv
// Per-port calculator request/response bundle: the bench drives requests through
// the master modport, the engine answers through the slave modport.
`timescale 1ns/1ps

interface calc_resp_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, drop_cnt
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, drop_cnt
    );
endinterface

// File: rtl/calc_resp_engine.sv
// Single-port calculator responder: two-cycle request capture, request FIFO, execute FSM.
// Optional macro CALC_SHIFT_EN enables the shift-left/shift-right commands (5/6).
`timescale 1ns/1ps

module calc_resp_engine #(
    parameter int QDEPTH = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    calc_resp_if.slave  bus
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT2, RESP} state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } entry_t;

    // Returns {resp, data} for add, subtract and every command treated as invalid.
    function automatic logic [33:0] exec_arith(input logic [3:0] cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1:    exec_arith = sum[32] ? {2'd2, 32'd0} : {2'd1, sum[31:0]};
            4'd2:    exec_arith = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            default: exec_arith = {2'd2, 32'd0};
        endcase
    endfunction

`ifdef CALC_SHIFT_EN
    function automatic logic [31:0] exec_shift(input logic left,
                                               input logic [31:0] a,
                                               input logic [4:0]  sh);
        exec_shift = left ? (a << sh) : (a >> sh);
    endfunction
`endif

    state_t          state_q, state_d;
    logic            cap_vld_q, cap_vld_d;
    logic [3:0]      cap_cmd_q;
    logic [31:0]     cap_op1_q;
    entry_t          mem_q [QDEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      drop_q, drop_d;
    entry_t          wk_q;
    logic [1:0]      out_resp_q, out_resp_d;
    logic [31:0]     out_data_q, out_data_d;

    logic            push, push_ok, drop, pop, empty, full;
    entry_t          push_entry;
    logic [33:0]     arith_res;
`ifdef CALC_SHIFT_EN
    logic            is_shift;
    logic [31:0]     shift_res;
`endif

    // A nonzero command is only recognised when the capture stage is not in its op2 cycle.
    always_comb begin
        cap_vld_d = 1'b0;
        if (!cap_vld_q && bus.req_cmd_in != 4'd0) begin
            cap_vld_d = 1'b1;
        end
    end

    assign push       = cap_vld_q;
    assign push_entry = {cap_cmd_q, cap_op1_q, bus.req_data_in};
    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == FULL_CNT);
    assign push_ok    = push && (!full || pop);
    assign drop       = push && full && !pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    assign arith_res = exec_arith(wk_q.cmd, wk_q.op1, wk_q.op2);
`ifdef CALC_SHIFT_EN
    assign is_shift  = (wk_q.cmd == 4'd5) || (wk_q.cmd == 4'd6);
    assign shift_res = exec_shift(wk_q.cmd == 4'd5, wk_q.op1, wk_q.op2[4:0]);
`endif

    // Output registers are loaded only on the transition into RESP and fall back to zero otherwise.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        out_resp_d = 2'd0;
        out_data_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d                  = RESP;
                {out_resp_d, out_data_d} = arith_res;
`ifdef CALC_SHIFT_EN
                if (is_shift) begin
                    state_d    = SHIFT2;
                    out_resp_d = 2'd0;
                    out_data_d = 32'd0;
                end
`endif
            end
            SHIFT2: begin
`ifdef CALC_SHIFT_EN
                state_d    = RESP;
                out_resp_d = 2'd1;
                out_data_d = shift_res;
`else
                state_d    = IDLE;
`endif
            end
            RESP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cap_vld_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            drop_q     <= 8'd0;
            out_resp_q <= 2'd0;
            out_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cap_vld_q  <= cap_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
        end
    end

    // Payload storage carries no reset; occupancy and FSM state decide whether it is meaningful.
    always_ff @(posedge c_clk) begin
        if (cap_vld_d) begin
            cap_cmd_q <= bus.req_cmd_in;
            cap_op1_q <= bus.req_data_in;
        end
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
        if (pop) begin
            wk_q <= mem_q[rd_ptr_q];
        end
    end

    assign bus.out_resp = out_resp_q;
    assign bus.out_data = out_data_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_calc_resp_engine.sv
// Self-checking bench for calc_resp_engine: scenario tasks drive requests and compare the
// observed response stream and drop count against a queue/service-time reference model.
`timescale 1ns/1ps

module tb_calc_resp_engine;

    localparam int QD = 4;

    typedef struct {
        int          t;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  junk;
    } req_t;

    typedef struct {
        int          c;
        logic [1:0]  r;
        logic [31:0] d;
    } rsp_t;

    logic c_clk = 1'b0;
    logic reset;
    calc_resp_if bus();

    calc_resp_engine #(.QDEPTH(QD)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 c_clk = ~c_clk;

    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_drop_total = 0;
    int   exp_ncyc = 0;
    req_t scn[$];
    rsp_t exp_q[$];
    rsp_t obs_q[$];

    always @(posedge c_clk) cyc <= cyc + 1;

    always @(negedge c_clk) begin
        rsp_t x;
        if (bus.out_resp !== 2'd0) begin
            x.c = cyc - base;
            x.r = bus.out_resp;
            x.d = bus.out_data;
            obs_q.push_back(x);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Result of one request from the command rules, and cycles from pop to the response cycle.
    function automatic void ref_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d, output int lat);
        longint unsigned s;
        lat = 2;
        r   = 2'd2;
        d   = 32'd0;
        case (cmd)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s <= 64'h0000_0000_FFFF_FFFF) begin
                    r = 2'd1;
                    d = s[31:0];
                end
            end
            4'd2: begin
                if (b <= a) begin
                    r = 2'd1;
                    d = a - b;
                end
            end
`ifdef CALC_SHIFT_EN
            4'd5: begin r = 2'd1; d = a << b[4:0]; lat = 3; end
            4'd6: begin r = 2'd1; d = a >> b[4:0]; lat = 3; end
`endif
            default: ;
        endcase
    endfunction

    // Request i enters the queue at the edge ending cycle t+1; the server takes the queue head
    // at any edge once its previous job's response cycle has been reached.
    function automatic void build_expect();
        int         q[$];
        int         srv_free, e, k, drops, idx, lat, last;
        logic [1:0] r;
        logic [31:0] d;
        rsp_t       x;
        bit         popped;
        exp_q.delete();
        srv_free = 0;
        e = 0;
        k = 0;
        drops = 0;
        while (k < scn.size() || q.size() > 0) begin
            popped = 1'b0;
            if (q.size() > 0 && e >= srv_free) begin
                idx = q.pop_front();
                ref_op(scn[idx].cmd, scn[idx].a, scn[idx].b, r, d, lat);
                x.c = e + lat;
                x.r = r;
                x.d = d;
                exp_q.push_back(x);
                srv_free = e + lat;
                popped = 1'b1;
            end
            if (k < scn.size() && scn[k].t + 1 == e) begin
                if (q.size() < QD) q.push_back(k);
                else               drops++;
                k++;
            end
            e++;
        end
        exp_drop_total = (exp_drop_total + drops > 255) ? 255 : exp_drop_total + drops;
        last = 0;
        foreach (exp_q[i]) if (exp_q[i].c > last) last = exp_q[i].c;
        if (scn.size() > 0 && scn[scn.size()-1].t + 1 > last) last = scn[scn.size()-1].t + 1;
        exp_ncyc = last + 4;
    endfunction

    function automatic void add_req(input int t, input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] junk);
        req_t x;
        x.t = t; x.cmd = cmd; x.a = a; x.b = b; x.junk = junk;
        scn.push_back(x);
    endfunction

    // Drives the scenario cycle by cycle; inputs change 1ns after the rising edge.
    task automatic run_scn(input bit wait_edge, input int ncyc);
        int k = 0;
        if (wait_edge) begin
            @(posedge c_clk);
            #1;
        end
        base = cyc;
        obs_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (k < scn.size() && scn[k].t == c) begin
                bus.req_cmd_in  = scn[k].cmd;
                bus.req_data_in = scn[k].a;
            end else if (k < scn.size() && scn[k].t + 1 == c) begin
                bus.req_cmd_in  = scn[k].junk;
                bus.req_data_in = scn[k].b;
                k++;
            end else begin
                bus.req_cmd_in  = 4'd0;
                bus.req_data_in = $urandom;
            end
            @(posedge c_clk);
            #1;
        end
        bus.req_cmd_in = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_cmd_in  = 4'd0;
        bus.req_data_in = 32'd0;
        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        checks++;
        if (bus.out_resp !== 2'd0) begin errors++; $display("FAIL reset_resp got %0d exp 0", bus.out_resp); end
        checks++;
        if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
        checks++;
        if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.drop_cnt); end
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        exp_drop_total = 0;
        scn.delete();
        add_req(0, 4'd1, 32'h0000_0005, 32'h0000_0007, 4'd0);
        build_expect();
        run_scn(1'b0, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL first_add count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL first_add rsp%0d missing exp r=%0d d=%h", i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL first_add rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
    endtask

    task automatic test_add_sub();
        scn.delete();
        add_req(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0);
        add_req(2, 4'd2, 32'h0000_0003, 32'h0000_0005, 4'd0);
        add_req(4, 4'd2, 32'h0000_0005, 32'h0000_0003, 4'd0);
        add_req(6, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 4'd0);
        add_req(8, 4'd2, 32'h8000_0000, 32'h8000_0000, 4'd0);
        add_req(11, 4'd1, 32'h8000_0000, 32'h8000_0000, 4'd0);
        build_expect();
        run_scn(1'b1, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL add_sub count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL add_sub rsp%0d missing exp r=%0d d=%h", i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL add_sub rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
    endtask

    task automatic test_shift();
        scn.delete();
        add_req(0, 4'd5, 32'h8000_0001, 32'h0000_0021, 4'd0);
        add_req(6, 4'd6, 32'h8000_0000, 32'd31, 4'd0);
        add_req(12, 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'd0);
        add_req(18, 4'd6, 32'hF000_000F, 32'd4, 4'd0);
        build_expect();
        run_scn(1'b1, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL shift count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL shift rsp%0d missing exp r=%0d d=%h", i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL shift rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
    endtask

    task automatic test_invalid_ignore();
        scn.delete();
        add_req(0, 4'd9, 32'h0000_1234, 32'h0000_0001, 4'd0);
        add_req(2, 4'd1, 32'h0000_0010, 32'h0000_0020, 4'd3);
        add_req(4, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6);
        add_req(6, 4'd3, 32'h0000_0001, 32'h0000_0002, 4'd1);
        build_expect();
        run_scn(1'b1, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL invalid count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL invalid rsp%0d missing exp r=%0d d=%h", i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL invalid rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
        checks++;
        if (bus.drop_cnt !== 8'(exp_drop_total)) begin errors++; $display("FAIL invalid drop_cnt got %0d exp %0d", bus.drop_cnt, exp_drop_total); end
    endtask

    // Shift stream every 2 cycles with nrq requests; a long stream drives drop_cnt into saturation.
    task automatic test_back_to_back(input int nrq, input string name);
        scn.delete();
        for (int i = 0; i < nrq; i++) begin
            add_req(2 * i, (i % 2 == 0) ? 4'd5 : 4'd6, $urandom, 32'(i % 32), 4'($urandom_range(0, 15)));
        end
        build_expect();
        run_scn(1'b1, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s count got %0d exp %0d", name, obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL %s rsp%0d missing exp r=%0d d=%h", name, i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL %s rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", name, i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
        checks++;
        if (bus.drop_cnt !== 8'(exp_drop_total)) begin errors++; $display("FAIL %s drop_cnt got %0d exp %0d", name, bus.drop_cnt, exp_drop_total); end
    endtask

    task automatic test_random();
        int          t = 0;
        int          pick;
        logic [3:0]  cmd;
        logic [31:0] a, b;
        scn.delete();
        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4)      cmd = 4'd1;
            else if (pick < 7) cmd = 4'd2;
            else if (pick == 7) cmd = 4'd5;
            else if (pick == 8) cmd = 4'd6;
            else               cmd = 4'($urandom_range(1, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 8)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            add_req(t, cmd, a, b, 4'($urandom_range(0, 15)));
            t += 2 + (($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end
        build_expect();
        run_scn(1'b1, exp_ncyc);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL random rsp%0d missing exp r=%0d d=%h", i, exp_q[i].r, exp_q[i].d); end
            else if (obs_q[i].c !== exp_q[i].c || obs_q[i].r !== exp_q[i].r || obs_q[i].d !== exp_q[i].d) begin
                errors++;
                $display("FAIL random rsp%0d got c=%0d r=%0d d=%h exp c=%0d r=%0d d=%h", i,
                         obs_q[i].c, obs_q[i].r, obs_q[i].d, exp_q[i].c, exp_q[i].r, exp_q[i].d);
            end
        end
        checks++;
        if (bus.drop_cnt !== 8'(exp_drop_total)) begin errors++; $display("FAIL random drop_cnt got %0d exp %0d", bus.drop_cnt, exp_drop_total); end
    endtask

    task automatic test_reset_midexec();
        scn.delete();
        for (int i = 0; i < 5; i++) add_req(2 * i, 4'd5, $urandom, 32'd3, 4'd0);
        run_scn(1'b1, 10);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_resp !== 2'd0) begin errors++; $display("FAIL midreset_resp got %0d exp 0", bus.out_resp); end
        checks++;
        if (bus.out_data !== 32'd0) begin errors++; $display("FAIL midreset_data got %h exp 0", bus.out_data); end
        checks++;
        if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL midreset_drop got %0d exp 0", bus.drop_cnt); end
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        exp_drop_total = 0;
        base = cyc;
        obs_q.delete();
        repeat (12) @(posedge c_clk);
        @(negedge c_clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL post_reset responses got %0d exp 0", obs_q.size()); end
        checks++;
        if (bus.drop_cnt !== 8'(exp_drop_total)) begin errors++; $display("FAIL post_reset drop_cnt got %0d exp %0d", bus.drop_cnt, exp_drop_total); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_invalid_ignore();
        test_back_to_back(10, "back_to_back");
        test_random();
        test_back_to_back(900, "drop_sat");
        test_reset_midexec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_resp_engine.md
# calc_resp_engine

Single-port responder for the calculator request/response protocol: accepts a command with operand 1, takes operand 2 on the following cycle, queues the request, executes add/subtract/shift, and returns one response word per request. It is the DUT-side end of the per-port interface that the calculator bench drives; four instances form a four-port calculator.

## Interface
- QDEPTH, 4: request FIFO depth in entries (power of two, 2..16)
- c_clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low
- req_cmd_in  input  4  command; nonzero starts a request
- req_data_in  input  32  operand 1 with command, operand 2 on the following cycle
- out_resp  output  2  0 = no response, 1 = success, 2 = overflow/underflow/invalid, 3 never driven
- out_data  output  32  result; valid only when out_resp != 0
- drop_cnt  output  8  saturating count of requests lost to a full FIFO

## Operation
- Commands: 0 no-op; 1 add (op1 + op2); 2 subtract (op1 - op2); 5 shift left (op1 << op2[4:0]); 6 logical shift right (op1 >> op2[4:0]); all others invalid.
- Capture: cycle N with req_cmd_in != 0 latches {cmd, op1}; cycle N+1 latches op2 from req_data_in. req_cmd_in during N+1 is ignored, never starts a request. The next request can begin in N+2.
- Push {cmd, op1, op2} into the FIFO at the edge ending N+1. If the FIFO is full and no pop occurs on that edge, the request is dropped and drop_cnt increments (saturates at 255). Push and pop on the same edge when full: push accepted.
- FSM states: IDLE, EXEC, SHIFT2, RESP.
- IDLE: FIFO non-empty -> pop into work registers, go EXEC.
- EXEC: add/sub/invalid -> compute result, go RESP; shift -> go SHIFT2.
- SHIFT2: compute shift result, go RESP.
- RESP: out_resp/out_data hold the result for exactly one cycle; FIFO non-empty -> pop, go EXEC; else IDLE.
- Add: 33-bit sum; bit 32 set -> resp 2, data 0; else resp 1, data = sum[31:0].
- Subtract: op2 > op1 -> resp 2, data 0; else resp 1, data = op1 - op2.
- Shifts: bits shifted out are discarded; always resp 1. op2[31:5] ignored.
- Invalid command: resp 2, data 0.
- Outputs outside RESP: out_resp = 0, out_data = 0.
- Responses return in request order.

## Timing
- Reset values: out_resp 0, out_data 0, drop_cnt 0, FIFO empty, FSM IDLE, capture stage idle.
- Reset asserted mid-request or mid-execution: request is lost, no response produced; first command is recognised on the first rising edge after reset deasserts.
- Outputs are registered, loaded on entry to RESP, and cleared on exit.
- Latency, FIFO empty and FSM idle at cycle N: add/sub/invalid response visible in cycle N+4; shift in cycle N+5.
- Throughput: back-to-back add/sub every 2 cycles sustain without queue growth; back-to-back shifts (3 cycles each) grow the queue by one entry per 6 cycles.
- A command presented in the op2 cycle of a prior request is silently ignored and is not counted in drop_cnt.

## Configuration
- CALC_SHIFT_EN defined: commands 5 and 6 execute as above, including the SHIFT2 state.
- CALC_SHIFT_EN undefined: commands 5 and 6 are invalid (resp 2, data 0, response in N+4), SHIFT2 is unreachable, and no shifter logic is synthesised.

## Test plan
- Reset low for 3 cycles, then cmd 1, op1 0x0000_0005, op2 0x0000_0007 -> cycle N+4 out_resp 1, out_data 0x0000_000C, then resp 0.
- cmd 1, op1 0xFFFF_FFFF, op2 1 -> resp 2, data 0; cmd 2, op1 3, op2 5 -> resp 2, data 0; cmd 2, op1 5, op2 3 -> resp 1, data 2.
- cmd 5, op1 0x8000_0001, op2 0x0000_0021 -> cycle N+5 resp 1, data 0x0000_0002; cmd 6, op1 0x8000_0000, op2 31 -> data 1.
- Back-to-back cmd 5 requests every 2 cycles with QDEPTH 4 -> responses in order, no drops for the first 4 requests, and drop_cnt increments by exactly one per lost request.
- cmd 9, op1 0x1234 -> resp 2, data 0; cmd 3 in op2 cycle of an add -> ignored, only one response.
- Reset asserted while FSM in SHIFT2 with 2 queued -> outputs 0 immediately, no responses after release, drop_cnt 0.
